store_credit_ctrl: RTL

Store-issue controller between the commit stage and the write-through data cache. It arbitrates store requests from the commit ports round-robin and forwards at most one store per cycle to the cache. It bounds in-flight stores with a credit counter sized for MaxOutstandingStores. It also sequences fence drains, so that a fence completes only once every issued store has been acknowledged.

---
 rtl/store_credit_pkg.sv | 7 +
 rtl/store_credit_if.sv | 13 +
 rtl/store_credit_rr_arb.sv | 39 +++
 rtl/store_credit_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/store_credit_pkg.sv
// rtl/store_credit_pkg.sv - shared types and default sizing for the store credit controller
package store_credit_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} fence_state_e;

  localparam int STORE_CREDIT_NR_REQ          = 2;
  localparam int STORE_CREDIT_MAX_OUTSTANDING = 7;
endpackage

// File: rtl/store_credit_if.sv
// rtl/store_credit_if.sv - cache-side store issue/ack channel of the store credit controller
interface store_credit_if #(
  parameter int NrReq = 2,
  parameter int SelW  = (NrReq > 1) ? $clog2(NrReq) : 1
) ();
  logic            mem_valid_o;
  logic [SelW-1:0] mem_sel_o;
  logic            mem_ready_i;
  logic            mem_ack_i;

  modport master (output mem_valid_o, output mem_sel_o, input mem_ready_i, input mem_ack_i);
  modport slave  (input mem_valid_o, input mem_sel_o, output mem_ready_i, output mem_ack_i);
endinterface

// File: rtl/store_credit_rr_arb.sv
// rtl/store_credit_rr_arb.sv - round-robin arbiter; winner is the first request after the last grant
module store_credit_rr_arb #(
  parameter int NrReq = 2,
  parameter int IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NrReq-1:0] req_i,
  input  logic             enable_i,
  output logic [IdxW-1:0]  winner_o,
  output logic             valid_o,
  input  logic             advance_i
);
  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_winner;
  logic            w_found;

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 1; i <= NrReq; i++) begin
      if (!w_found && req_i[(int'(r_ptr) + i) % NrReq]) begin
        w_found  = 1'b1;
        w_winner = IdxW'((int'(r_ptr) + i) % NrReq);
      end
    end
  end

  assign valid_o  = enable_i & (|req_i);
  assign winner_o = valid_o ? w_winner : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr <= IdxW'(NrReq - 1);
    end else if (advance_i) begin
      r_ptr <= winner_o;
    end
  end
endmodule

// File: rtl/store_credit_ctrl.sv
// rtl/store_credit_ctrl.sv - store issue arbitration, credit counting and fence drain sequencing
// Optional stall counter: STORE_CREDIT_PERF_EN
module store_credit_ctrl
  import store_credit_pkg::*;
#(
  parameter int NrReq          = STORE_CREDIT_NR_REQ,
  parameter int MaxOutstanding = STORE_CREDIT_MAX_OUTSTANDING,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1),
  parameter int SelW           = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NrReq-1:0]    req_i,
  output logic [NrReq-1:0]    gnt_o,
  store_credit_if.master      mem,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                ack_err_o,
  output logic [31:0]         stall_cnt_o
);
  fence_state_e        r_state;
  logic [CntWidth-1:0] r_cnt;
  logic                r_full;
  logic                r_empty;
  logic                r_fence_done;
  logic                r_ack_err;
  logic                w_issue_en;
  logic                w_valid;
  logic                w_issue;
  logic                w_ack_ok;
  logic [SelW-1:0]     w_sel;
  logic [CntWidth-1:0] w_cnt_nxt;

  // Issue gating uses only registered count: an ack at full frees the credit next cycle
  assign w_issue_en = (r_state == IDLE) && !fence_i && (r_cnt < CntWidth'(MaxOutstanding));

  store_credit_rr_arb #(.NrReq(NrReq), .IdxW(SelW)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .enable_i  (w_issue_en),
    .winner_o  (w_sel),
    .valid_o   (w_valid),
    .advance_i (w_issue)
  );

  assign w_issue         = w_valid & mem.mem_ready_i;
  assign mem.mem_valid_o = w_valid;
  assign mem.mem_sel_o   = w_sel;
  assign gnt_o           = w_issue ? (NrReq'(1) << w_sel) : '0;

  // A spurious ack (count already 0) returns no credit
  assign w_ack_ok = mem.mem_ack_i && (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_issue && !w_ack_ok) w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_issue && w_ack_ok) w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_fence_done <= 1'b0;
      r_ack_err    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_full       <= (w_cnt_nxt == CntWidth'(MaxOutstanding));
      r_empty      <= (w_cnt_nxt == '0);
      r_fence_done <= 1'b0;
      if (mem.mem_ack_i && (r_cnt == '0)) r_ack_err <= 1'b1;
      case (r_state)
        IDLE:    if (fence_i) r_state <= DRAIN;
        DRAIN:   if ((r_cnt == '0) && !mem.mem_ack_i) begin
                   r_state      <= DONE;
                   r_fence_done <= 1'b1;
                 end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign outstanding_o = r_cnt;
  assign full_o        = r_full;
  assign empty_o       = r_empty;
  assign fence_done_o  = r_fence_done;
  assign ack_err_o     = r_ack_err;

`ifdef STORE_CREDIT_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if ((|req_i) && !w_valid && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif
endmodule
